// File: rtl/mips_pkg.sv
// Shared execute-stage definitions: operand width, multiplier FSM states,
// iteration counter width and an operand magnitude helper.
package mips_pkg;

    localparam int XLEN       = 32;
    localparam int MULT_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mult_state_t;

    // Magnitude of a signed operand, or the raw bits for unsigned operation.
    // The most negative value maps onto itself, which is correct as unsigned.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] value,
                                                input logic            is_sgn);
        abs_val = (is_sgn && value[XLEN-1]) ? (~value + 1'b1) : value;
    endfunction

endpackage

// File: rtl/mult_accum_step.sv
// One shift-and-add iteration: conditionally add the multiplicand into the
// upper accumulator half (33-bit sum including carry), then shift
// {carry, accumulator} right by one bit. Purely combinational.
module mult_accum_step
    import mips_pkg::*;
(
    input  logic [XLEN-1:0]   acc_hi,
    input  logic [XLEN-1:1]   acc_lo,
    input  logic [XLEN-1:0]   mcand,
    input  logic              add_en,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] sum;

    // Add stage and one-bit right shift; bit 0 of the old accumulator falls off.
    always_comb begin
        sum      = {1'b0, acc_hi} + (add_en ? {1'b0, mcand} : {(XLEN+1){1'b0}});
        acc_next = {sum, acc_lo};
    end

endmodule

// File: rtl/hilo_multiplier.sv
// Multi-cycle 32x32 MULT/MULTU unit owning the HI/LO register pair, with
// MTHI/MTLO writes and continuous HI/LO read-out.
// Optional feature macro: MULT_EARLY_EXIT_EN (finish early once the remaining
// multiplier bits are zero, using a barrel shift of the accumulator).
module hilo_multiplier
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    mult_state_t             state;
    mult_state_t             state_next;
    logic [XLEN-1:0]         mcand;
    logic [XLEN-1:0]         mplr;
    logic [2*XLEN-1:0]       acc;
    logic [MULT_CNT_W-1:0]   cnt;
    logic                    neg;

    logic [2*XLEN-1:0]       acc_step;
    logic [2*XLEN-1:0]       acc_calc_next;
    logic                    calc_last;
    logic [2*XLEN-1:0]       product;

    mult_accum_step u_step (
        .acc_hi   (acc[2*XLEN-1:XLEN]),
        .acc_lo   (acc[XLEN-1:1]),
        .mcand    (mcand),
        .add_en   (mplr[0]),
        .acc_next (acc_step)
    );

`ifdef MULT_EARLY_EXIT_EN
    logic                  mplr_zero;
    logic [MULT_CNT_W-1:0] remaining;

    // Once no set multiplier bits remain, the rest of the iterations are pure
    // shifts, so collapse them into a single barrel shift.
    always_comb begin
        mplr_zero     = (mplr == '0);
        remaining     = MULT_CNT_W'(XLEN) - cnt;
        acc_calc_next = mplr_zero ? (acc >> remaining) : acc_step;
        calc_last     = mplr_zero || (cnt == MULT_CNT_W'(XLEN - 1));
    end
`else
    // Fixed schedule: one add-and-shift per cycle for all XLEN iterations.
    always_comb begin
        acc_calc_next = acc_step;
        calc_last     = (cnt == MULT_CNT_W'(XLEN - 1));
    end
`endif

    // Final sign correction of the unsigned magnitude product.
    always_comb begin
        product = neg ? (~acc + 1'b1) : acc;
    end

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)     state_next = CALC;
            CALC:    if (calc_last) state_next = FIX;
            FIX:                    state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Output decode: the pipeline stalls while an iteration or fix-up is pending.
    always_comb begin
        busy = (state == CALC) || (state == FIX);
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= abs_val(a, is_signed);
                        mplr  <= abs_val(b, is_signed);
                        neg   <= is_signed & (a[XLEN-1] ^ b[XLEN-1]);
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    acc  <= acc_calc_next;
                    mplr <= mplr >> 1;
                    cnt  <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Architectural HI/LO: product on FIX, MTHI/MTLO only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            hi <= product[2*XLEN-1:XLEN];
            lo <= product[XLEN-1:0];
        end else if (state == IDLE) begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
        end
    end

    // Completion pulse, high for the cycle after HI/LO take the product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done <= 1'b0;
        else     done <= (state == FIX);
    end

endmodule

// File: tb/tb_hilo_multiplier.sv
// Self-checking bench for hilo_multiplier (default build, fixed latency).
module tb_hilo_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    localparam int MULT_LATENCY = 33;  // edges after the start edge until done is seen

    hilo_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [63:0] ref_product(input bit sgn, input logic [31:0] x,
                                                input logic [31:0] y);
        longint sx, sy;
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    // One multiply from IDLE. disturb: at iteration 10 pulse start with other
    // operands plus MTHI/MTLO (all must be ignored). with_write: MTHI in the
    // same cycle as start (must be applied, then overwritten by the product).
    task automatic do_mult(input string tag, input bit sgn, input logic [31:0] x,
                           input logic [31:0] y, input bit disturb, input bit with_write);
        logic [63:0] prod;
        int          lat;
        bit          seen;
        prod = ref_product(sgn, x, y);
        start = 1'b1; is_signed = sgn; a = x; b = y;
        if (with_write) begin
            wr_hi = 1'b1;
            wdata = 32'h5A5A_0000 ^ x;
        end
        tick;
        start = 1'b0; wr_hi = 1'b0;
        a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
        if (with_write) begin
            exp_hi = 32'h5A5A_0000 ^ x;
            check({tag, "_mthi_with_start"}, {32'b0, hi}, {32'b0, exp_hi});
        end
        check({tag, "_busy_start"}, {63'b0, busy}, 64'd1);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            if (disturb && lat == 9) begin
                start = 1'b1; a = 32'd3; b = 32'd5;
                wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h1234;
            end
            tick;
            start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
            lat++;
            if (done) seen = 1'b1;
            else if (lat == 17) begin
                check({tag, "_hold_mid"}, {hi, lo}, {exp_hi, exp_lo});
                check({tag, "_busy_mid"}, {63'b0, busy}, 64'd1);
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(MULT_LATENCY));
        exp_hi = prod[63:32];
        exp_lo = prod[31:0];
        check({tag, "_product"}, {hi, lo}, prod);
        check({tag, "_busy_done"}, {63'b0, busy}, 64'd0);
        tick;
        check({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
        check({tag, "_hilo_stable"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        int done_cnt;

        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        rst = 1'b0;
        tick;

        // MTHI, MTLO, then both at once.
        wr_hi = 1'b1; wdata = 32'h1111_2222;
        tick;
        wr_hi = 1'b0;
        exp_hi = 32'h1111_2222;
        check("mthi", {hi, lo}, {exp_hi, exp_lo});
        wr_lo = 1'b1; wdata = 32'h3333_4444;
        tick;
        wr_lo = 1'b0;
        exp_lo = 32'h3333_4444;
        check("mtlo", {hi, lo}, {exp_hi, exp_lo});
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hCAFE_F00D;
        tick;
        wr_hi = 1'b0; wr_lo = 1'b0;
        exp_hi = 32'hCAFE_F00D; exp_lo = 32'hCAFE_F00D;
        check("mthi_mtlo", {hi, lo}, {exp_hi, exp_lo});

        // Directed products.
        do_mult("multu_ones", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_mult("mult_neg3x7", 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        do_mult("mult_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        do_mult("multu_dec", 1'b0, 32'd345678, 32'd987654, 1'b0, 1'b0);
        do_mult("mult_zero", 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        do_mult("mult_mixed", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);

        // Start and MTHI/MTLO during CALC are ignored.
        do_mult("ignore_mid", 1'b0, 32'h0001_0003, 32'h0002_0005, 1'b1, 1'b0);

        // MTHI in the same cycle as start.
        do_mult("wr_with_start", 1'b1, 32'hFFFF_FF00, 32'h0000_1234, 1'b0, 1'b1);

        // Randomized operands and signedness.
        for (int i = 0; i < 8; i++) begin
            do_mult($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    1'b0, 1'b0);
        end

        // Reset during CALC aborts at once, with no completion pulse.
        start = 1'b1; is_signed = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        tick;
        start = 1'b0;
        repeat (19) tick;
        rst = 1'b1;
        #1;
        exp_hi = '0; exp_lo = '0;
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_done", {63'b0, done}, 64'd0);
        tick;
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (done) done_cnt++;
        end
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        check("midrst_idle", {63'b0, busy}, 64'd0);
        wr_lo = 1'b1; wdata = 32'h0000_ABCD;
        tick;
        wr_lo = 1'b0;
        exp_lo = 32'h0000_ABCD;
        check("post_rst_mtlo", {hi, lo}, {exp_hi, exp_lo});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
